// File: rtl/vram_pkg.sv
// Shared defaults, size derivations and FSM state encoding for the double-buffered VRAM.
// Optional feature macro: VRAM_DBUF_CLEAR_EN (adds the CLEAR state).
`timescale 1ns/1ps
package vram_pkg;

  localparam int H_RES_DEF      = 128;
  localparam int V_RES_DEF      = 96;
  localparam int ADDR_W_DEF     = 14;
  localparam int COLOR_BITS_DEF = 1;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_PENDING = 2'd1;
  localparam state_t ST_CLEAR   = 2'd2;

  function automatic int calc_depth(input int h_res, input int v_res);
    return h_res * v_res;
  endfunction

  function automatic int calc_pix_w(input int color_bits);
    return 3 * color_bits;
  endfunction

endpackage

// File: rtl/vram_bank.sv
// One VRAM bank: simple dual-port RAM, one write port and one registered read port.
// Contents are never reset; callers keep addresses below DEPTH.
`timescale 1ns/1ps
module vram_bank #(
  parameter int DEPTH  = 12288,
  parameter int ADDR_W = 14,
  parameter int PIX_W  = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [PIX_W-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [PIX_W-1:0]  rdata_p1
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_p1 <= mem[raddr];
    end
  end

endmodule

// File: rtl/vram_dbuf.sv
// Double-buffered VGA video RAM: display reads the front bank, drawing writes the back bank,
// swaps commit on vsync. Define VRAM_DBUF_CLEAR_EN to zero the new back bank after each swap.
`timescale 1ns/1ps
module vram_dbuf
  import vram_pkg::*;
#(
  parameter int H_RES      = H_RES_DEF,
  parameter int V_RES      = V_RES_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int COLOR_BITS = COLOR_BITS_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rd_en,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [COLOR_BITS-1:0]   red_col,
  output logic [COLOR_BITS-1:0]   green_col,
  output logic [COLOR_BITS-1:0]   blue_col,
  output logic                    rd_valid,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [3*COLOR_BITS-1:0] wr_data,
  output logic                    wr_ready,
  input  logic                    swap_req,
  input  logic                    vsync,
  output logic                    swap_pending,
  output logic                    swap_ack,
  output logic                    front_sel
);

  localparam int DEPTH = calc_depth(H_RES, V_RES);
  localparam int PIX_W = calc_pix_w(COLOR_BITS);
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < DEPTH_W;
  endfunction

  state_t state_q, state_d;
  logic   front_q, front_d;
  logic   ack_q;
  logic   commit;

`ifdef VRAM_DBUF_CLEAR_EN
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);
  logic [ADDR_W-1:0] clr_q, clr_d;
  logic              in_clear;
  assign in_clear = (state_q == ST_CLEAR);
`endif

  // Swap FSM: a request waits in PENDING for the frame strobe
  always_comb begin
    state_d = state_q;
    front_d = front_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (swap_req) begin
          if (vsync) begin
            commit = 1'b1;
          end else begin
            state_d = ST_PENDING;
          end
        end
      end
      ST_PENDING: begin
        if (vsync) begin
          commit = 1'b1;
        end
      end
`ifdef VRAM_DBUF_CLEAR_EN
      ST_CLEAR: begin
        if (clr_q == CLR_LAST) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    if (commit) begin
      front_d = ~front_q;
`ifdef VRAM_DBUF_CLEAR_EN
      state_d = ST_CLEAR;
`else
      state_d = ST_IDLE;
`endif
    end
  end

`ifdef VRAM_DBUF_CLEAR_EN
  always_comb begin
    clr_d = clr_q;
    if (commit) begin
      clr_d = '0;
    end else if (in_clear) begin
      clr_d = clr_q + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      front_q <= 1'b0;
      ack_q   <= 1'b0;
`ifdef VRAM_DBUF_CLEAR_EN
      clr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      front_q <= front_d;
      ack_q   <= commit;
`ifdef VRAM_DBUF_CLEAR_EN
      clr_q   <= clr_d;
`endif
    end
  end

  assign swap_pending = (state_q == ST_PENDING);
  assign swap_ack     = ack_q;
  assign front_sel    = front_q;

  // Back-bank write port, shared by the drawing logic and the clear sweep
  logic              bk_we;
  logic [ADDR_W-1:0] bk_waddr;
  logic [PIX_W-1:0]  bk_wdata;

`ifdef VRAM_DBUF_CLEAR_EN
  assign wr_ready = ~in_clear;
  always_comb begin
    bk_we    = wr_en && wr_ready && in_range(wr_addr);
    bk_waddr = wr_addr;
    bk_wdata = wr_data;
    if (in_clear) begin
      bk_we    = 1'b1;
      bk_waddr = clr_q;
      bk_wdata = '0;
    end
  end
`else
  assign wr_ready = 1'b1;
  always_comb begin
    bk_we    = wr_en && in_range(wr_addr);
    bk_waddr = wr_addr;
    bk_wdata = wr_data;
  end
`endif

  // Stage p0: capture address, bank select and range check together
  logic              vld_p0, vld_p1, vld_p2;
  logic [ADDR_W-1:0] raddr_p0;
  logic              sel_p0, inr_p0;
  logic              sel_p1, inr_p1;

  always_ff @(posedge clk) begin
    if (rd_en) begin
      raddr_p0 <= rd_addr;
      sel_p0   <= front_q;
      inr_p0   <= in_range(rd_addr);
    end
  end

  // Stage p1: RAM output register inside each bank
  logic [PIX_W-1:0] rdata0_p1, rdata1_p1;

  vram_bank #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .PIX_W (PIX_W)
  ) u_bank0 (
    .clk     (clk),
    .we      (bk_we && front_q),
    .waddr   (bk_waddr),
    .wdata   (bk_wdata),
    .re      (vld_p0 && inr_p0 && !sel_p0),
    .raddr   (raddr_p0),
    .rdata_p1(rdata0_p1)
  );

  vram_bank #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .PIX_W (PIX_W)
  ) u_bank1 (
    .clk     (clk),
    .we      (bk_we && !front_q),
    .waddr   (bk_waddr),
    .wdata   (bk_wdata),
    .re      (vld_p0 && inr_p0 && sel_p0),
    .raddr   (raddr_p0),
    .rdata_p1(rdata1_p1)
  );

  always_ff @(posedge clk) begin
    if (vld_p0) begin
      sel_p1 <= sel_p0;
      inr_p1 <= inr_p0;
    end
  end

  // Stage p2: bank mux, out-of-range blanking and output register
  logic [PIX_W-1:0] pix_p1;
  logic [PIX_W-1:0] pix_p2;

  assign pix_p1 = !inr_p1 ? '0 : (sel_p1 ? rdata1_p1 : rdata0_p1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      pix_p2 <= '0;
    end else begin
      vld_p0 <= rd_en;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        pix_p2 <= pix_p1;
      end
    end
  end

  assign rd_valid  = vld_p2;
  assign red_col   = pix_p2[3*COLOR_BITS-1:2*COLOR_BITS];
  assign green_col = pix_p2[2*COLOR_BITS-1:COLOR_BITS];
  assign blue_col  = pix_p2[COLOR_BITS-1:0];

endmodule

// File: tb/tb_vram_dbuf.sv
// Directed self-checking bench for vram_dbuf at default geometry (128x96, 1 bit per channel).
`timescale 1ns/1ps
module tb_vram_dbuf;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_en;
  logic [13:0] rd_addr;
  logic        red_col, green_col, blue_col;
  logic        rd_valid;
  logic        wr_en;
  logic [13:0] wr_addr;
  logic [2:0]  wr_data;
  logic        wr_ready;
  logic        swap_req, vsync;
  logic        swap_pending, swap_ack, front_sel;
  logic [2:0]  pix_o;

  int n_tests = 0;
  int n_fail  = 0;

  assign pix_o = {red_col, green_col, blue_col};

  always #5 clk = ~clk;

  vram_dbuf dut (
    .clk         (clk),
    .reset       (reset),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .red_col     (red_col),
    .green_col   (green_col),
    .blue_col    (blue_col),
    .rd_valid    (rd_valid),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .swap_req    (swap_req),
    .vsync       (vsync),
    .swap_pending(swap_pending),
    .swap_ack    (swap_ack),
    .front_sel   (front_sel)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready;
    int k;
    k = 0;
    while (wr_ready !== 1'b1 && k < 20000) begin
      tick;
      k++;
    end
    if (k >= 20000) check("wr_ready_timeout", {31'd0, wr_ready}, 32'd1);
  endtask

  task automatic write_px(input logic [13:0] a, input logic [2:0] d);
    wait_ready;
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick;
    wr_en   = 1'b0;
  endtask

  task automatic read_px(input logic [13:0] a, input logic [2:0] exp, input string tag);
    rd_en   = 1'b1;
    rd_addr = a;
    tick;
    rd_en   = 1'b0;
    tick;
    tick;
    check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
    check({tag, "_data"}, {29'd0, pix_o}, {29'd0, exp});
  endtask

  task automatic swap_delayed;
    wait_ready;
    swap_req = 1'b1;
    tick;
    swap_req = 1'b0;
    tick;
    tick;
    vsync = 1'b1;
    tick;
    vsync = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] ra [5];
    logic [2:0]  rexp [5];
    int          cnt;
    ra   = '{14'd0, 14'd1, 14'd8, 14'd18, 14'd199};
    rexp = '{3'd5, 3'd6, 3'd3, 3'd7, 3'd2};

    reset = 1'b0; rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; swap_req = 1'b0; vsync = 1'b0;
    repeat (3) tick;
    check("rst_pix", {29'd0, pix_o}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_pending", {31'd0, swap_pending}, 32'd0);
    check("rst_ack", {31'd0, swap_ack}, 32'd0);
    check("rst_front", {31'd0, front_sel}, 32'd0);
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    reset = 1'b1;
    tick;

    // Fill back bank (bank 1), then swap with vsync three cycles after the request
    for (int i = 0; i < 5; i++) write_px(ra[i], rexp[i]);
    swap_req = 1'b1;
    tick;
    swap_req = 1'b0;
    check("pend_c1", {31'd0, swap_pending}, 32'd1);
    tick;
    check("pend_c2", {31'd0, swap_pending}, 32'd1);
    tick;
    check("pend_c3", {31'd0, swap_pending}, 32'd1);
    check("pend_no_ack", {31'd0, swap_ack}, 32'd0);
    vsync = 1'b1;
    tick;
    vsync = 1'b0;
    check("commit_pend", {31'd0, swap_pending}, 32'd0);
    check("commit_ack", {31'd0, swap_ack}, 32'd1);
    check("commit_front", {31'd0, front_sel}, 32'd1);
    tick;
    check("ack_one_cycle", {31'd0, swap_ack}, 32'd0);

    // Single read: not yet valid one edge after sampling, valid after two
    rd_en = 1'b1; rd_addr = 14'd0;
    tick;
    rd_en = 1'b0;
    tick;
    check("rd_lat_early", {31'd0, rd_valid}, 32'd0);
    tick;
    check("rd0_valid", {31'd0, rd_valid}, 32'd1);
    check("rd0_rgb", {29'd0, pix_o}, 32'd5);

    tick;
    for (int i = 0; i < 7; i++) begin
      rd_en = (i < 5);
      if (i < 5) rd_addr = ra[i];
      tick;
      if (i >= 2) begin
        check("b2b_valid", {31'd0, rd_valid}, 32'd1);
        check("b2b_data", {29'd0, pix_o}, {29'd0, rexp[i-2]});
      end
    end
    rd_en = 1'b0;
    tick;
    check("hold_valid", {31'd0, rd_valid}, 32'd0);
    check("hold_data", {29'd0, pix_o}, 32'd2);

    rd_en = 1'b1; rd_addr = 14'd12288;
    tick;
    rd_en = 1'b0;
    tick;
    tick;
    check("oor_valid", {31'd0, rd_valid}, 32'd1);
    check("oor_black", {29'd0, pix_o}, 32'd0);

    // Back bank is now bank 0; the write to 16383 must not alias onto 4095
    write_px(14'd0, 3'd4);
    write_px(14'd4095, 3'd1);
    write_px(14'd16383, 3'd7);

    // Same-cycle request and strobe, with a write and a read on the commit edge
    wait_ready;
    swap_req = 1'b1; vsync = 1'b1;
    wr_en = 1'b1; wr_addr = 14'd1; wr_data = 3'd5;
    rd_en = 1'b1; rd_addr = 14'd0;
    tick;
    swap_req = 1'b0; vsync = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    check("imm_front", {31'd0, front_sel}, 32'd0);
    check("imm_ack", {31'd0, swap_ack}, 32'd1);
    check("imm_pend", {31'd0, swap_pending}, 32'd0);
    tick;
    check("imm_ack_drop", {31'd0, swap_ack}, 32'd0);
    tick;
    check("oldfront_valid", {31'd0, rd_valid}, 32'd1);
    check("oldfront_data", {29'd0, pix_o}, 32'd5);
    tick;
    read_px(14'd0, 3'd4, "newfront0");
    read_px(14'd4095, 3'd1, "noalias");
    read_px(14'd1, 3'd5, "commit_write");

    // Second request while pending is absorbed: one commit, one ack
    wait_ready;
    swap_req = 1'b1;
    tick;
    swap_req = 1'b0;
    tick;
    swap_req = 1'b1;
    tick;
    swap_req = 1'b0;
    check("dbl_pend", {31'd0, swap_pending}, 32'd1);
    vsync = 1'b1;
    tick;
    vsync = 1'b0;
    check("dbl_front", {31'd0, front_sel}, 32'd1);
    check("dbl_ack", {31'd0, swap_ack}, 32'd1);
`ifdef VRAM_DBUF_CLEAR_EN
    check("clr_busy", {31'd0, wr_ready}, 32'd0);
    cnt = 0;
    while (wr_ready !== 1'b1 && cnt < 20000) begin
      tick;
      cnt++;
    end
    check("clr_len", cnt, 32'd12288);
`else
    check("no_clr_ready", {31'd0, wr_ready}, 32'd1);
`endif
    repeat (4) tick;
    check("dbl_ack_once", {31'd0, swap_ack}, 32'd0);
    check("dbl_pend_clr", {31'd0, swap_pending}, 32'd0);
    check("dbl_front_hold", {31'd0, front_sel}, 32'd1);

    // Bank 0 returns to the front: stale frame, or zeros when cleared
    swap_delayed;
    check("swap3_front", {31'd0, front_sel}, 32'd0);
`ifdef VRAM_DBUF_CLEAR_EN
    read_px(14'd0, 3'd0, "cleared");
`else
    read_px(14'd0, 3'd4, "stale");
`endif
    tick;
    reset = 1'b0;
    #1;
    check("rst_mid_ready", {31'd0, wr_ready}, 32'd1);
    check("rst_mid_pend", {31'd0, swap_pending}, 32'd0);
    reset = 1'b1;
    tick;

    // Reset during PENDING drops the request
    swap_delayed;
    check("pre_rst_front", {31'd0, front_sel}, 32'd1);
    wait_ready;
    swap_req = 1'b1;
    tick;
    swap_req = 1'b0;
    check("pre_rst_pend", {31'd0, swap_pending}, 32'd1);
    reset = 1'b0;
    #1;
    check("rstp_pend", {31'd0, swap_pending}, 32'd0);
    check("rstp_front", {31'd0, front_sel}, 32'd0);
    reset = 1'b1;
    tick;
    vsync = 1'b1;
    tick;
    vsync = 1'b0;
    check("rstp_no_swap", {31'd0, front_sel}, 32'd0);
    check("rstp_no_ack", {31'd0, swap_ack}, 32'd0);
    tick;
    check("rstp_idle", {31'd0, swap_pending}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_dbuf.md
# vram_dbuf

Parametrised, double-buffered video RAM for the VGA display path. The display controller reads RGB pixels from the front bank by linear address, while the drawing logic writes the back bank. A requested bank swap commits only on a frame-boundary strobe, so the display never shows a half-drawn frame. It generalises the single-bank, 1-bit-per-channel VRAM to configurable resolution and colour depth, and adds a write port, a swap handshake and registered read latency.

## Interface
- H_RES, 128: pixels per line
- V_RES, 96: lines per frame; DEPTH = H_RES*V_RES words per bank
- ADDR_W, 14: address width; must satisfy 2^ADDR_W >= DEPTH
- COLOR_BITS, 1: bits per colour channel; PIX_W = 3*COLOR_BITS
- clk  in  1  system clock; all logic is on the rising edge
- reset  in  1  asynchronous, active-low reset
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  linear pixel address, y*H_RES+x, into the front bank
- red_col / green_col / blue_col  out  COLOR_BITS each  pixel data
- rd_valid  out  1  high when colour outputs hold the data for a read issued 2 cycles earlier
- wr_en  in  1  write request to the back bank
- wr_addr  in  ADDR_W  write address
- wr_data  in  PIX_W  {R,G,B}, with R in the MSBs
- wr_ready  out  1  writes are accepted only while high
- swap_req  in  1  single-cycle request to exchange banks
- vsync  in  1  single-cycle frame-boundary strobe
- swap_pending  out  1  a swap has been requested but not yet committed
- swap_ack  out  1  one-cycle pulse on the cycle after a swap commits
- front_sel  out  1  index of the current front bank

## Operation
- Two banks of DEPTH x PIX_W. Bank front_sel is read-only to the display. Bank ~front_sel is write-only.
- Reads: address and front_sel are sampled together when rd_en is high. An address >= DEPTH returns all-zero (black) with rd_valid still asserted. When rd_en is low, the colour outputs hold their previous value.
- Writes: the write happens on the edge where wr_en && wr_ready is high. A write with wr_addr >= DEPTH is dropped silently.
- FSM states are IDLE, PENDING and CLEAR. CLEAR exists only with the macro.
- IDLE: swap_req moves the FSM to PENDING. If vsync is high in the same cycle, the swap commits immediately instead.
- PENDING: swap_pending=1. On vsync, front_sel toggles, swap_ack pulses, and the FSM goes to IDLE, or to CLEAR when the macro is defined. Further swap_req pulses are ignored.
- swap_req in CLEAR is ignored and no ack is given. Software retries after wr_ready returns high.
- A write on the same edge as a swap commit lands in the pre-swap back bank, which becomes the new front.
- Reset values: red/green/blue=0, rd_valid=0, swap_pending=0, swap_ack=0, front_sel=0, wr_ready=1, FSM in IDLE. Reset does not clear RAM contents.
- Reset asserted in mid-PENDING or mid-CLEAR drops the request or clear at once, and the RAM is left as written so far.

## Timing
- Read latency is 2 cycles: address register, then RAM output register. A read at edge N gives valid data after edge N+2. Fully pipelined, one read per cycle.
- A read issued at or before the commit edge returns old-front data, even if it completes after the swap.
- Write latency is 1 cycle into the RAM. Throughput is one write per cycle while wr_ready is high.
- swap_ack is high for exactly 1 cycle, starting the cycle after the commit edge.
- There is no combinational path from inputs to outputs.

## Configuration
- VRAM_DBUF_CLEAR_EN defined:
  - After each commit, the FSM enters CLEAR and writes zero to every address of the new back bank, one word per cycle, for DEPTH cycles.
  - wr_ready stays low for those DEPTH cycles, then the FSM returns to IDLE.
- Not defined: there is no CLEAR state, wr_ready is tied to 1, and the back bank keeps the stale frame after a swap.

## Structure
- Package vram_pkg holds the H_RES/V_RES defaults, the DEPTH and PIX_W derivations, and the FSM state typedef (IDLE, PENDING, CLEAR).
- Sub-module vram_bank is a simple dual-port RAM with 1 write port and 1 registered read port, instantiated twice.
- The top level holds the FSM, front_sel, the clear counter, the read pipeline, the out-of-range masking and the output registers.

## Test plan
- Reset, then write 0x5 to addr 0 of the back bank, then swap_req followed 3 cycles later by vsync -> swap_pending is high for 3 cycles and swap_ack pulses once. A read of addr 0 then gives R=1, G=0, B=1 two cycles after rd_en.
- Back-to-back reads of addrs 0, 1, 8, 18, 199 -> rd_valid is high continuously, and the data matches a model at a 2-cycle offset.
- Read of addr 12288 with the defaults -> black with rd_valid=1. Write to addr 16383 -> no bank contents change.
- swap_req and vsync in the same cycle -> front_sel flips at that edge and swap_ack follows next cycle. A second swap_req while PENDING gives only one ack.
- With VRAM_DBUF_CLEAR_EN: after a swap, wr_ready is low for exactly 12288 cycles and the back bank reads all zero. Reset pulsed mid-clear returns wr_ready=1 and IDLE at once.
- Reset asserted mid-PENDING -> swap_pending=0, front_sel=0, and vsync afterwards causes no swap.
